// File: rtl/pipe_perf_monitor.sv
// Run-control and performance monitor for the pipelined RISC-V core: counts cycles, stalls,
// flushes, retires and generic events, detects ebreak, drains, and enforces a timeout.
// Optional build macro PIPE_PERF_MON_SAT_EN: saturating counters plus a sticky ovf_o flag.
module pipe_perf_monitor #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned NUM_EVT      = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned MAX_CYCLES   = 100,
    parameter logic [31:0] EBREAK_WORD  = 32'h00100073
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               retire_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [31:0]        pc_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    input  logic [SEL_W-1:0]   evt_sel_i,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o,
    output logic [CNT_W-1:0]   retire_cnt_o,
    output logic [CNT_W-1:0]   evt_cnt_o,
    output logic [31:0]        ebreak_pc_o,
    output logic [2:0]         state_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               ovf_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0] evt_cnt_q [NUM_EVT];
    logic [CNT_W-1:0] evt_cnt_d [NUM_EVT];
    logic [31:0]      ebreak_pc_q, ebreak_pc_d;
    logic [7:0]       drain_q, drain_d;

    logic active;
    logic ebreak_hit;
    logic timeout_hit;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef PIPE_PERF_MON_SAT_EN
        return (&v) ? v : v + CNT_ONE;
`else
        return v + CNT_ONE;
`endif
    endfunction

    assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ebreak_hit = instr_valid_i && (instr_i == EBREAK_WORD);
    // Compared in 64 bits so a MAX_CYCLES wider than the counter can never match by truncation.
    assign timeout_hit = (64'(cycle_cnt_q) + 64'd1) == 64'(MAX_CYCLES);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through this block infers a latch.
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        evt_cnt_d    = evt_cnt_q;
        ebreak_pc_d  = ebreak_pc_q;
        drain_d      = drain_q;

        if (clear_i) begin
            state_d      = ST_IDLE;
            cycle_cnt_d  = '0;
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            retire_cnt_d = '0;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = '0;
            ebreak_pc_d  = '0;
            drain_d      = '0;
        end else begin
            if (active) begin
                cycle_cnt_d = cnt_inc(cycle_cnt_q);
                if (flush_i)      flush_cnt_d = cnt_inc(flush_cnt_q);
                else if (stall_i) stall_cnt_d = cnt_inc(stall_cnt_q);
                if (retire_i)     retire_cnt_d = cnt_inc(retire_cnt_q);
                for (int k = 0; k < NUM_EVT; k++) begin
                    if (evt_i[k]) evt_cnt_d[k] = cnt_inc(evt_cnt_q[k]);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (timeout_hit) begin
                        state_d = ST_TIMEOUT;
                    end else if (ebreak_hit) begin
                        ebreak_pc_d = pc_i;
                        drain_d     = 8'(DRAIN_CYCLES);
                        state_d     = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_d = drain_q - 8'd1;
                    if (timeout_hit)          state_d = ST_TIMEOUT;
                    else if (drain_q <= 8'd1) state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= '0;
            ebreak_pc_q  <= '0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            evt_cnt_q    <= evt_cnt_d;
            ebreak_pc_q  <= ebreak_pc_d;
            drain_q      <= drain_d;
        end
    end

`ifdef PIPE_PERF_MON_SAT_EN
    logic ovf_q, ovf_d;

    // Any increment attempted on an all-ones counter marks the run as overflowed.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_i) begin
            ovf_d = 1'b0;
        end else if (active) begin
            if (&cycle_cnt_q)                           ovf_d = 1'b1;
            if (flush_i && (&flush_cnt_q))              ovf_d = 1'b1;
            if (!flush_i && stall_i && (&stall_cnt_q))  ovf_d = 1'b1;
            if (retire_i && (&retire_cnt_q))            ovf_d = 1'b1;
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k] && (&evt_cnt_q[k]))        ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    always_comb begin
        evt_cnt_o = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (32'(evt_sel_i) == 32'(k)) evt_cnt_o = evt_cnt_q[k];
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
    assign ebreak_pc_o  = ebreak_pc_q;
    assign state_o      = state_q;
    assign done_o       = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    assign timeout_o    = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Bench for pipe_perf_monitor: directed scenarios with inline checks plus a randomized run
// compared against a cycle-level behavioural model; a second narrow instance covers wrap/saturation.
module tb_pipe_perf_monitor;

    localparam int          NUM_EVT = 4;
    localparam int          DRAIN   = 5;
    localparam int          MAXC    = 100;
    localparam logic [31:0] EBREAK  = 32'h00100073;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3, S_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, clear, stall, flush, retire, instr_valid;
    logic [3:0]  evt;
    logic [31:0] pc, instr;
    logic [1:0]  sel;

    logic [31:0] cycle_o, stall_o, flush_o, retire_o, evt_o, ebpc_o;
    logic [2:0]  state_o;
    logic        done_o, timeout_o, ovf_o;

    logic [3:0]  n_cycle, n_stall, n_flush, n_retire, n_evt;
    logic [31:0] n_ebpc;
    logic [2:0]  n_state;
    logic        n_done, n_timeout, n_ovf;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (used by the randomized test only).
    bit          model_on = 1'b0;
    longint      m_cycle, m_stall, m_flush, m_retire;
    longint      m_evt [NUM_EVT];
    logic [31:0] m_pc;
    int          m_state, m_drain_left;

    pipe_perf_monitor dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .retire_i(retire), .evt_i(evt),
        .pc_i(pc), .instr_i(instr), .instr_valid_i(instr_valid), .evt_sel_i(sel),
        .cycle_cnt_o(cycle_o), .stall_cnt_o(stall_o), .flush_cnt_o(flush_o),
        .retire_cnt_o(retire_o), .evt_cnt_o(evt_o), .ebreak_pc_o(ebpc_o),
        .state_o(state_o), .done_o(done_o), .timeout_o(timeout_o), .ovf_o(ovf_o)
    );

    pipe_perf_monitor #(.CNT_W(4), .NUM_EVT(3), .SEL_W(2)) dut4 (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .clear_i(clear),
        .stall_i(stall), .flush_i(flush), .retire_i(retire), .evt_i(evt[2:0]),
        .pc_i(pc), .instr_i(instr), .instr_valid_i(instr_valid), .evt_sel_i(sel),
        .cycle_cnt_o(n_cycle), .stall_cnt_o(n_stall), .flush_cnt_o(n_flush),
        .retire_cnt_o(n_retire), .evt_cnt_o(n_evt), .ebreak_pc_o(n_ebpc),
        .state_o(n_state), .done_o(n_done), .timeout_o(n_timeout), .ovf_o(n_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic longint m_inc(input longint v);
        longint top;
        top = 64'h0000_0000_FFFF_FFFF;
`ifdef PIPE_PERF_MON_SAT_EN
        return (v >= top) ? top : v + 1;
`else
        return (v + 1) & top;
`endif
    endfunction

    task automatic m_zero();
        m_cycle = 0; m_stall = 0; m_flush = 0; m_retire = 0;
        for (int k = 0; k < NUM_EVT; k++) m_evt[k] = 0;
        m_pc = '0; m_state = S_IDLE; m_drain_left = 0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit hits_limit;
        if (!rst_n || clear) begin
            m_zero();
        end else if (m_state == S_IDLE) begin
            if (start) m_state = S_RUN;
        end else if (m_state == S_RUN || m_state == S_DRAIN) begin
            hits_limit = (m_cycle + 1 == MAXC);
            m_cycle = m_inc(m_cycle);
            if (flush)      m_flush = m_inc(m_flush);
            else if (stall) m_stall = m_inc(m_stall);
            if (retire)     m_retire = m_inc(m_retire);
            for (int k = 0; k < NUM_EVT; k++) if (evt[k]) m_evt[k] = m_inc(m_evt[k]);
            if (hits_limit) begin
                m_state = S_TIMEOUT;
            end else if (m_state == S_RUN) begin
                if (instr_valid && instr == EBREAK) begin
                    m_pc = pc; m_drain_left = DRAIN; m_state = S_DRAIN;
                end
            end else begin
                m_drain_left--;
                if (m_drain_left == 0) m_state = S_DONE;
            end
        end
    endtask

    task automatic tick();
        if (model_on) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; clear = 0; stall = 0; flush = 0; retire = 0; evt = '0;
        pc = '0; instr = 32'h13; instr_valid = 0; sel = '0;
    endtask

    task automatic begin_run();
        idle_inputs();
        clear = 1; tick(); clear = 0;
        start = 1; tick(); start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); start = 1; stall = 1; evt = 4'hF;
        tick(); tick();
        checks++; if (cycle_o !== 0 || stall_o !== 0 || flush_o !== 0 || retire_o !== 0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0/0/0/0", cycle_o, stall_o, flush_o, retire_o); end
        checks++; if (evt_o !== 0 || ebpc_o !== 0) begin
            errors++; $display("FAIL reset_evt_pc: got %0h/%0h expected 0/0", evt_o, ebpc_o); end
        checks++; if (state_o !== 3'(S_IDLE) || done_o !== 0 || timeout_o !== 0 || ovf_o !== 0) begin
            errors++; $display("FAIL reset_status: got %0d/%b/%b/%b expected 0/0/0/0", state_o, done_o, timeout_o, ovf_o); end
        checks++; if ({n_cycle, n_stall, n_flush, n_retire, n_evt} !== 20'h0 || n_ebpc !== 0 || n_state !== 3'(S_IDLE) || {n_done, n_timeout, n_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_narrow: got %0h/%0h/%0d expected 0/0/0", {n_cycle, n_stall, n_flush, n_retire, n_evt}, n_ebpc, n_state); end
        rst_n = 1; idle_inputs(); tick();
        checks++; if (state_o !== 3'(S_IDLE)) begin
            errors++; $display("FAIL reset_release_state: got %0d expected %0d", state_o, S_IDLE); end
    endtask

    task automatic test_stall();
        begin_run();
        stall = 1;
        repeat (10) tick();
        stall = 0;
        checks++; if (stall_o !== 32'd10) begin errors++; $display("FAIL stall_cnt: got %0d expected 10", stall_o); end
        checks++; if (flush_o !== 32'd0) begin errors++; $display("FAIL stall_flush_cnt: got %0d expected 0", flush_o); end
        checks++; if (cycle_o !== 32'd10) begin errors++; $display("FAIL stall_cycle_cnt: got %0d expected 10", cycle_o); end
    endtask

    task automatic test_flush_priority();
        begin_run();
        stall = 1; flush = 1;
        repeat (3) tick();
        stall = 0; flush = 0;
        checks++; if (flush_o !== 32'd3) begin errors++; $display("FAIL flush_cnt: got %0d expected 3", flush_o); end
        checks++; if (stall_o !== 32'd0) begin errors++; $display("FAIL flush_masks_stall: got %0d expected 0", stall_o); end
    endtask

    task automatic test_ebreak_drain();
        begin_run();
        for (int c = 1; c <= 20; c++) begin
            instr_valid = 1;
            pc    = (c == 20) ? 32'h40 : 32'(c * 4);
            instr = (c == 20) ? EBREAK : 32'h13;
            tick();
        end
        checks++; if (state_o !== 3'(S_DRAIN) || ebpc_o !== 32'h40 || cycle_o !== 32'd20) begin
            errors++; $display("FAIL ebreak_enter: got state %0d pc %0h cycle %0d expected 2 40 20", state_o, ebpc_o, cycle_o); end
        pc = 32'h80; instr = EBREAK;
        for (int d = 1; d <= 5; d++) begin
            tick();
            checks++; if (state_o !== ((d < 5) ? 3'(S_DRAIN) : 3'(S_DONE))) begin
                errors++; $display("FAIL drain_state_%0d: got %0d expected %0d", d, state_o, (d < 5) ? S_DRAIN : S_DONE); end
        end
        checks++; if (done_o !== 1 || timeout_o !== 0 || cycle_o !== 32'd25 || ebpc_o !== 32'h40) begin
            errors++; $display("FAIL done: got done %b to %b cycle %0d pc %0h expected 1 0 25 40", done_o, timeout_o, cycle_o, ebpc_o); end
        start = 1; stall = 1;
        repeat (3) tick();
        idle_inputs();
        checks++; if (state_o !== 3'(S_DONE) || cycle_o !== 32'd25 || stall_o !== 32'd0) begin
            errors++; $display("FAIL done_sticky: got state %0d cycle %0d stall %0d expected 3 25 0", state_o, cycle_o, stall_o); end
    endtask

    task automatic test_timeout();
        begin_run();
        retire = 1; instr_valid = 1;
        for (int c = 1; c <= 100; c++) begin
            pc    = (c == 100) ? 32'h1234 : 32'(c * 4);
            instr = (c == 100) ? EBREAK : 32'h13;
            tick();
            if (c == 99) begin
                checks++; if (state_o !== 3'(S_RUN) || cycle_o !== 32'd99) begin
                    errors++; $display("FAIL pre_timeout: got state %0d cycle %0d expected 1 99", state_o, cycle_o); end
            end
        end
        checks++; if (state_o !== 3'(S_TIMEOUT) || timeout_o !== 1 || done_o !== 1) begin
            errors++; $display("FAIL timeout_state: got %0d/%b/%b expected 4/1/1", state_o, timeout_o, done_o); end
        checks++; if (cycle_o !== 32'd100 || retire_o !== 32'd100 || ebpc_o !== 32'h0) begin
            errors++; $display("FAIL timeout_counts: got cycle %0d retire %0d pc %0h expected 100 100 0", cycle_o, retire_o, ebpc_o); end
        stall = 1; flush = 1; evt = 4'hF; start = 1; sel = 0;
        repeat (10) tick();
        idle_inputs();
        checks++; if (cycle_o !== 32'd100 || flush_o !== 0 || stall_o !== 0 || retire_o !== 32'd100 || evt_o !== 0) begin
            errors++; $display("FAIL timeout_frozen: got %0d/%0d/%0d/%0d/%0d expected 100/0/0/100/0", cycle_o, flush_o, stall_o, retire_o, evt_o); end
        checks++; if (state_o !== 3'(S_TIMEOUT)) begin
            errors++; $display("FAIL timeout_sticky: got %0d expected 4", state_o); end
    endtask

    task automatic test_events_clear();
        begin_run();
        evt = 4'b1010;
        repeat (7) tick();
        evt = 4'b0000;
        sel = 2'd1; #1;
        checks++; if (evt_o !== 32'd7) begin errors++; $display("FAIL evt_sel1: got %0d expected 7", evt_o); end
        checks++; if (n_evt !== 4'd7) begin errors++; $display("FAIL narrow_evt_sel1: got %0d expected 7", n_evt); end
        sel = 2'd0; #1;
        checks++; if (evt_o !== 32'd0) begin errors++; $display("FAIL evt_sel0: got %0d expected 0", evt_o); end
        sel = 2'd3; #1;
        checks++; if (evt_o !== 32'd7) begin errors++; $display("FAIL evt_sel3: got %0d expected 7", evt_o); end
        checks++; if (n_evt !== 4'd0) begin errors++; $display("FAIL narrow_evt_sel_oob: got %0d expected 0", n_evt); end
        clear = 1; start = 1; evt = 4'hF; stall = 1;
        tick();
        idle_inputs(); sel = 2'd3;
        checks++; if (cycle_o !== 0 || stall_o !== 0 || evt_o !== 0 || state_o !== 3'(S_IDLE)) begin
            errors++; $display("FAIL clear_priority: got cycle %0d stall %0d evt %0d state %0d expected 0 0 0 0", cycle_o, stall_o, evt_o, state_o); end
    endtask

    task automatic test_reset_mid_drain();
        begin_run();
        instr_valid = 1; instr = EBREAK; pc = 32'h10; stall = 1;
        tick();
        instr_valid = 0;
        tick();
        checks++; if (state_o !== 3'(S_DRAIN) || ebpc_o !== 32'h10) begin
            errors++; $display("FAIL mid_drain_setup: got %0d/%0h expected 2/10", state_o, ebpc_o); end
        rst_n = 0;
        tick();
        checks++; if (state_o !== 3'(S_IDLE) || cycle_o !== 0 || stall_o !== 0 || ebpc_o !== 0 || done_o !== 0) begin
            errors++; $display("FAIL reset_mid_drain: got state %0d cycle %0d stall %0d pc %0h done %b expected all 0", state_o, cycle_o, stall_o, ebpc_o, done_o); end
        rst_n = 1; idle_inputs();
        start = 1; tick(); start = 0;
        stall = 1; repeat (3) tick(); stall = 0;
        checks++; if (cycle_o !== 32'd3 || stall_o !== 32'd3 || state_o !== 3'(S_RUN) || ebpc_o !== 0) begin
            errors++; $display("FAIL no_residue: got cycle %0d stall %0d state %0d pc %0h expected 3 3 1 0", cycle_o, stall_o, state_o, ebpc_o); end
    endtask

    task automatic test_narrow_counter();
        logic [3:0] exp_cnt;
        logic       exp_ovf;
`ifdef PIPE_PERF_MON_SAT_EN
        exp_cnt = 4'd15; exp_ovf = 1'b1;
`else
        exp_cnt = 4'd1;  exp_ovf = 1'b0;
`endif
        begin_run();
        stall = 1;
        repeat (17) tick();
        stall = 0;
        checks++; if (n_stall !== exp_cnt || n_cycle !== exp_cnt) begin
            errors++; $display("FAIL narrow_stall: got stall %0d cycle %0d expected %0d", n_stall, n_cycle, exp_cnt); end
        checks++; if (n_ovf !== exp_ovf || n_flush !== 0 || n_retire !== 0 || n_state !== 3'(S_RUN)) begin
            errors++; $display("FAIL narrow_ovf: got ovf %b flush %0d retire %0d state %0d expected %b 0 0 1", n_ovf, n_flush, n_retire, n_state, exp_ovf); end
        checks++; if (stall_o !== 32'd17 || ovf_o !== 0) begin
            errors++; $display("FAIL wide_stall: got %0d ovf %b expected 17 0", stall_o, ovf_o); end
    endtask

    task automatic test_random();
        m_zero();
        model_on = 1;
        for (int r = 0; r < 6; r++) begin
            begin_run();
            for (int c = 0; c < 115; c++) begin
                stall       = ($urandom_range(0, 2) == 0);
                flush       = ($urandom_range(0, 4) == 0);
                retire      = 1'($urandom_range(0, 1));
                evt         = 4'($urandom);
                sel         = 2'($urandom);
                start       = ($urandom_range(0, 7) == 0);
                pc          = $urandom & 32'h0000_FFFC;
                instr_valid = ($urandom_range(0, 3) != 0);
                instr       = (r > 0 && $urandom_range(0, 10 * r) == 0) ? EBREAK
                                                                       : (($urandom & 32'hFFF0_0000) | 32'h13);
                tick();
                checks++; if (state_o !== 3'(m_state) || done_o !== (m_state >= S_DONE) || timeout_o !== (m_state == S_TIMEOUT)) begin
                    errors++; $display("FAIL rnd_state r%0d c%0d: got %0d/%b/%b expected %0d", r, c, state_o, done_o, timeout_o, m_state); end
                checks++; if (cycle_o !== 32'(m_cycle) || stall_o !== 32'(m_stall) || flush_o !== 32'(m_flush)) begin
                    errors++; $display("FAIL rnd_cnt r%0d c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", r, c, cycle_o, stall_o, flush_o, m_cycle, m_stall, m_flush); end
                checks++; if (retire_o !== 32'(m_retire) || evt_o !== 32'(m_evt[sel]) || ebpc_o !== m_pc) begin
                    errors++; $display("FAIL rnd_misc r%0d c%0d: got %0d/%0d/%0h expected %0d/%0d/%0h", r, c, retire_o, evt_o, ebpc_o, m_retire, m_evt[sel], m_pc); end
            end
        end
        model_on = 0;
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_stall();
        test_flush_priority();
        test_ebreak_drain();
        test_timeout();
        test_events_clear();
        test_reset_mid_drain();
        test_narrow_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
